spi_frame_ctrl: RTL

Frame sequencer for the SPI master shift datapath. It generates SCLK (CPOL/CPHA-aware) and the active-low slave select, and produces every control strobe the shift datapath consumes: load, shift/sample enables, leading/trailing edge pulses, frame-active, frame-done and bit count. It sits between the APB register file (start, config, divider) and the shift datapath.

---
 rtl/spi_frame_ctrl_if.sv | 41 ++++
 rtl/spi_frame_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/spi_frame_ctrl_if.sv
// Control bus between the register block / shift datapath and the SPI frame
// sequencer. "slave" is the sequencer side, "master" is the side driving
// start/config and consuming the strobes.
interface spi_frame_ctrl_if #(
  parameter int DIV_W = 8
);
  logic             i_start;
  logic             i_abort;
  logic             i_cpol;
  logic             i_cpha;
  logic             i_wls;
  logic [DIV_W-1:0] i_div;

  logic             o_sclk;
  logic             o_ss_n;
  logic             o_busy;
  logic             o_tx_load;
  logic             o_shift_en;
  logic             o_sample_en;
  logic             o_leading_edge;
  logic             o_trailing_edge;
  logic             o_frame_active;
  logic             o_frame_done;
  logic             o_cpha;
  logic             o_wls;
  logic [4:0]       o_bit_cnt;

  modport master (
    output i_start, i_abort, i_cpol, i_cpha, i_wls, i_div,
    input  o_sclk, o_ss_n, o_busy, o_tx_load, o_shift_en, o_sample_en,
           o_leading_edge, o_trailing_edge, o_frame_active, o_frame_done,
           o_cpha, o_wls, o_bit_cnt
  );

  modport slave (
    input  i_start, i_abort, i_cpol, i_cpha, i_wls, i_div,
    output o_sclk, o_ss_n, o_busy, o_tx_load, o_shift_en, o_sample_en,
           o_leading_edge, o_trailing_edge, o_frame_active, o_frame_done,
           o_cpha, o_wls, o_bit_cnt
  );
endinterface

// File: rtl/spi_frame_ctrl.sv
// SPI master frame sequencer: generates SCLK and slave select and every
// control strobe of the shift datapath. Config is latched on the accepted
// start and held for the whole frame. All outputs come straight from flops.
module spi_frame_ctrl #(
  parameter int DIV_W = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  spi_frame_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETUP, S_XFER, S_HOLD, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_cnt_q, div_cnt_d;
  logic [4:0]       edge_cnt_q, bit_cnt_q, n_bits;
  logic             cpol_q, cpha_q, wls_q, lead_nxt_q;
  logic             sclk_q, ss_n_q, busy_q, tx_load_q, xfer_q;
  logic             lead_q, trail_q, active_q, done_q;
  logic             div_tc, pulse_d;

  assign n_bits = wls_q ? 5'd16 : 5'd8;
  assign div_tc = (div_cnt_q == div_q);

  // Next state and divider count; an edge pulse is scheduled for any XFER
  // cycle whose divider count will sit at terminal count.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    case (state_q)
      S_IDLE:  if (bus.i_start) state_d = S_LOAD;
      S_LOAD: begin
        state_d   = S_SETUP;
        div_cnt_d = '0;
      end
      S_SETUP: begin
        if (div_tc) begin
          state_d   = S_XFER;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      S_XFER: begin
        // The cycle carrying the N-th trailing pulse is the last XFER cycle
        if (trail_q && (edge_cnt_q == n_bits)) begin
          state_d   = S_HOLD;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_tc ? '0 : div_cnt_q + DIV_W'(1);
        end
      end
      S_HOLD: begin
        if (div_tc) state_d = S_DONE;
        else        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if ((state_q != S_IDLE) && bus.i_abort) begin
      state_d   = S_IDLE;
      div_cnt_d = '0;
    end
    pulse_d = (state_d == S_XFER) && (div_cnt_d == div_q);
  end

  // Frame FSM state, config latch, counters and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      bit_cnt_q  <= 5'd8;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      wls_q      <= 1'b0;
      lead_nxt_q <= 1'b0;
      sclk_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      tx_load_q  <= 1'b0;
      xfer_q     <= 1'b0;
      lead_q     <= 1'b0;
      trail_q    <= 1'b0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;

      if ((state_q == S_IDLE) && bus.i_start) begin
        cpol_q    <= bus.i_cpol;
        cpha_q    <= bus.i_cpha;
        wls_q     <= bus.i_wls;
        div_q     <= bus.i_div;
        bit_cnt_q <= bus.i_wls ? 5'd16 : 5'd8;
      end

      // Edges alternate leading/trailing; only trailing edges are counted
      lead_q  <= pulse_d &  lead_nxt_q;
      trail_q <= pulse_d & ~lead_nxt_q;
      if (state_d == S_LOAD) begin
        lead_nxt_q <= 1'b1;
        edge_cnt_q <= '0;
      end else if (pulse_d) begin
        lead_nxt_q <= ~lead_nxt_q;
        if (!lead_nxt_q) edge_cnt_q <= edge_cnt_q + 5'd1;
      end

      // SCLK follows live CPOL while idle, toggles the cycle after a pulse
      if (state_q == S_IDLE)        sclk_q <= bus.i_cpol;
      else if (state_d != S_XFER)   sclk_q <= cpol_q;
      else if (lead_q || trail_q)   sclk_q <= ~sclk_q;

      ss_n_q    <= !((state_d == S_LOAD) || (state_d == S_SETUP) ||
                     (state_d == S_XFER) || (state_d == S_HOLD));
      busy_q    <= (state_d != S_IDLE);
      tx_load_q <= (state_d == S_LOAD);
      xfer_q    <= (state_d == S_XFER);
      active_q  <= (state_d == S_SETUP) || (state_d == S_XFER) ||
                   (state_d == S_HOLD);
      done_q    <= (state_d == S_DONE);
    end
  end

  assign bus.o_sclk          = sclk_q;
  assign bus.o_ss_n          = ss_n_q;
  assign bus.o_busy          = busy_q;
  assign bus.o_tx_load       = tx_load_q;
  assign bus.o_shift_en      = xfer_q;
  assign bus.o_sample_en     = xfer_q;
  assign bus.o_leading_edge  = lead_q;
  assign bus.o_trailing_edge = trail_q;
  assign bus.o_frame_active  = active_q;
  assign bus.o_frame_done    = done_q;
  assign bus.o_cpha          = cpha_q;
  assign bus.o_wls           = wls_q;
  assign bus.o_bit_cnt       = bit_cnt_q;

endmodule
